// File: rtl/uart_pkg.sv
// Shared UART datapath definitions: shift-register operation encodings.
package uart_pkg;

    typedef logic [1:0] shreg_mode_t;

    localparam shreg_mode_t MODE_HOLD = 2'b00;
    localparam shreg_mode_t MODE_UP   = 2'b01;
    localparam shreg_mode_t MODE_DN   = 2'b10;
    localparam shreg_mode_t MODE_LOAD = 2'b11;

endpackage

// File: rtl/shreg_frame_cnt.sv
// Frame counter for the universal shift register: counts shifts and pulses
// done for one cycle after every WIDTH-th shift; a load restarts the frame.
module shreg_frame_cnt #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             shift,
    input  logic             load,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);
    import uart_pkg::*;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (en) begin
            if (load) begin
                cnt_d = '0;
            end else if (shift) begin
                if (cnt_q == LAST) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign cnt  = cnt_q;
    assign done = done_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift up/down, parallel load, frame counter.
// Define UNIV_SHIFT_REG_PARITY_EN to add the registered parity output par.
module univ_shift_reg
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             ser_a,
    input  logic             ser_b,
    input  logic             ser_dn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             so_up,
    output logic             so_dn,
    output logic [CNT_W-1:0] cnt,
    output logic             done
`ifdef UNIV_SHIFT_REG_PARITY_EN
    ,
    output logic             par
`endif
);

    shreg_mode_t      mode_s;
    logic [WIDTH-1:0] q_q, q_d;
    logic             shift, load;

    assign mode_s = shreg_mode_t'(mode);
    assign shift  = (mode_s == MODE_UP) || (mode_s == MODE_DN);
    assign load   = (mode_s == MODE_LOAD);

    always_comb begin
        q_d = q_q;
        if (en) begin
            case (mode_s)
                MODE_UP:   q_d = {q_q[WIDTH-2:0], ser_a & ser_b};
                MODE_DN:   q_d = {ser_dn, q_q[WIDTH-1:1]};
                MODE_LOAD: q_d = d;
                default:   q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) q_q <= '0;
        else     q_q <= q_d;
    end

    assign q     = q_q;
    assign so_up = q_q[WIDTH-1];
    assign so_dn = q_q[0];

    shreg_frame_cnt #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_frame_cnt (
        .clk   (clk),
        .clr   (clr),
        .en    (en),
        .shift (shift),
        .load  (load),
        .cnt   (cnt),
        .done  (done)
    );

`ifdef UNIV_SHIFT_REG_PARITY_EN
    // Parity is taken from the next-state value so par always matches q.
    logic par_q;
    always_ff @(posedge clk or posedge clr) begin
        if (clr) par_q <= 1'b0;
        else     par_q <= ^q_d;
    end
    assign par = par_q;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed scenarios plus randomized
// traffic against an arithmetic reference model.
module tb_univ_shift_reg;

    localparam int W     = 8;
    localparam int CW    = $clog2(W + 1);
    localparam int MASK  = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic          en = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic          ser_a = 1'b0, ser_b = 1'b0, ser_dn = 1'b0;
    logic [W-1:0]  d = '0;
    logic [W-1:0]  q;
    logic          so_up, so_dn, done;
    logic [CW-1:0] cnt;
`ifdef UNIV_SHIFT_REG_PARITY_EN
    logic          par;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_q = 0, m_cnt = 0, m_done = 0;

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk    (clk),
        .clr    (clr),
        .en     (en),
        .mode   (mode),
        .ser_a  (ser_a),
        .ser_b  (ser_b),
        .ser_dn (ser_dn),
        .d      (d),
        .q      (q),
        .so_up  (so_up),
        .so_dn  (so_dn),
        .cnt    (cnt),
        .done   (done)
`ifdef UNIV_SHIFT_REG_PARITY_EN
        ,
        .par    (par)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q = 0; m_cnt = 0; m_done = 0;
    endtask

    // Applies the operation selected by the inputs held across the last edge.
    task automatic model_step();
        m_done = 0;
        if (en) begin
            case (mode)
                2'b01: begin
                    m_q = ((m_q << 1) | int'(ser_a & ser_b)) & MASK;
                    m_cnt++;
                end
                2'b10: begin
                    m_q = (m_q >> 1) | (int'(ser_dn) << (W - 1));
                    m_cnt++;
                end
                2'b11: begin
                    m_q = int'(d);
                    m_cnt = 0;
                end
                default: ;
            endcase
            if (m_cnt == W) begin
                m_cnt = 0;
                m_done = 1;
            end
        end
    endtask

    task automatic compare(input string tag);
        check({tag, "_q"},     32'(q),     32'(m_q));
        check({tag, "_cnt"},   32'(cnt),   32'(m_cnt));
        check({tag, "_done"},  32'(done),  32'(m_done));
        check({tag, "_so_up"}, 32'(so_up), 32'((m_q >> (W - 1)) & 1));
        check({tag, "_so_dn"}, 32'(so_dn), 32'(m_q & 1));
`ifdef UNIV_SHIFT_REG_PARITY_EN
        check({tag, "_par"},   32'(par),   32'($countones(m_q) & 1));
`endif
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        model_step();
        compare(tag);
    endtask

    task automatic drive(input logic e, input logic [1:0] m);
        en = e;
        mode = m;
    endtask

    // Drives an up-shift bit as the AND of the two serial inputs.
    task automatic set_up_bit(input logic b);
        int r;
        if (b) begin
            ser_a = 1'b1; ser_b = 1'b1;
        end else begin
            r = $urandom_range(0, 2);
            ser_a = (r == 1);
            ser_b = (r == 2);
        end
    endtask

    initial begin
        logic [7:0] seq2;
        logic [7:0] exp3 [4];
        logic [3:0] so3;

        // Reset state
        #2;
        model_reset();
        compare("reset");
        @(negedge clk);
        clr = 1'b0;

        // Test 1: async clear mid-frame
        drive(1'b1, 2'b11); d = 8'h0B;
        tick("t1_load");
        drive(1'b1, 2'b01);
        set_up_bit(1'b1); tick("t1_s1");
        set_up_bit(1'b0); tick("t1_s2");
        set_up_bit(1'b0); tick("t1_s3");
        check("t1_pre_q", 32'(q), 32'h5C);
        check("t1_pre_cnt", 32'(cnt), 32'd3);
        drive(1'b1, 2'b00);
        #2 clr = 1'b1;
        #1;
        model_reset();
        compare("t1_clr");
        #1 clr = 1'b0;

        // Test 2: shift-up frame of 1,0,0,0,1,1,0,1 from zero
        seq2 = 8'b1000_1101;
        drive(1'b1, 2'b01);
        for (int i = 7; i >= 0; i--) begin
            set_up_bit(seq2[i]);
            tick("t2_shift");
        end
        check("t2_q", 32'(q), 32'h8D);
        check("t2_done", 32'(done), 32'd1);
        check("t2_cnt", 32'(cnt), 32'd0);
        drive(1'b1, 2'b00);
        tick("t2_after");
        check("t2_done_gone", 32'(done), 32'd0);

        // Test 3: load A5 then shift down four times
        exp3 = '{8'h52, 8'h29, 8'h14, 8'h0A};
        so3 = 4'b0101;
        drive(1'b1, 2'b11); d = 8'hA5;
        tick("t3_load");
        drive(1'b1, 2'b10); ser_dn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t3_so_dn_before", 32'(so_dn), 32'(so3[i]));
            tick("t3_shift");
            check("t3_q", 32'(q), 32'(exp3[i]));
        end
        check("t3_cnt", 32'(cnt), 32'd4);

        // Test 4: enable low holds everything
        drive(1'b1, 2'b11); d = 8'h3C;
        tick("t4_load");
        drive(1'b0, 2'b01); set_up_bit(1'b1);
        for (int i = 0; i < 3; i++) begin
            tick("t4_hold");
            check("t4_q", 32'(q), 32'h3C);
        end

        // Test 5: partial frame, load restarts the count
        drive(1'b1, 2'b01);
        for (int i = 0; i < 5; i++) begin
            set_up_bit(1'($urandom)); tick("t5_pre");
        end
        drive(1'b1, 2'b11); d = 8'hFF;
        tick("t5_load");
        drive(1'b1, 2'b10);
        for (int i = 1; i <= 8; i++) begin
            ser_dn = 1'($urandom);
            tick("t5_shift");
            check("t5_cnt", 32'(cnt), 32'(i % 8));
            check("t5_done", 32'(done), 32'(i == 8));
        end

        // Load on the edge that would complete the frame
        drive(1'b1, 2'b01);
        for (int i = 0; i < 7; i++) begin
            set_up_bit(1'($urandom)); tick("tl_pre");
        end
        drive(1'b1, 2'b11); d = 8'h96;
        tick("tl_load");
        check("tl_done", 32'(done), 32'd0);
        check("tl_cnt", 32'(cnt), 32'd0);

`ifdef UNIV_SHIFT_REG_PARITY_EN
        // Test 6: parity follows q
        drive(1'b1, 2'b11); d = 8'h07;
        tick("t6_load");
        check("t6_par_load", 32'(par), 32'd1);
        drive(1'b1, 2'b01); set_up_bit(1'b1);
        tick("t6_shift");
        check("t6_q", 32'(q), 32'h0F);
        check("t6_par_shift", 32'(par), 32'd0);
`endif

        // Randomized traffic with occasional async clear
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 9) != 0);
            mode = 2'($urandom);
            if (mode == 2'b11 && $urandom_range(0, 2) != 0) mode = 2'($urandom_range(1, 2));
            ser_a = 1'($urandom); ser_b = 1'($urandom); ser_dn = 1'($urandom);
            d = 8'($urandom);
            tick("rnd");
            if ($urandom_range(0, 49) == 0) begin
                #2 clr = 1'b1;
                #1;
                model_reset();
                compare("rnd_clr");
                #1 clr = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised universal shift register; next generation of the team's 8-bit serial-in/parallel-out shifter.
- Adds configurable width, bidirectional shift, parallel load, hold and a shift counter that flags a complete frame.
- Sits between the UART bit-sampling logic and the byte-level datapath.
- Used for both receive (serial-in, parallel-out) and transmit (parallel-in, serial-out).

Parameters:
- WIDTH, 8, register width in bits; legal values 2..32.
- CNT_W, $clog2(WIDTH+1), shift-counter width; derived, must not be overridden.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- clr  in  1  asynchronous active-high reset; clears all state immediately.
- en  in  1  clock enable; when 0 the block holds all state.
- mode  in  2  operation select: 00 hold, 01 shift up, 10 shift down, 11 parallel load.
- ser_a  in  1  serial input A for shift up.
- ser_b  in  1  serial input B for shift up; the shifted-in bit is ser_a AND ser_b.
- ser_dn  in  1  serial input for shift down.
- d  in  WIDTH  parallel load data.
- q  out  WIDTH  register contents.
- so_up  out  1  equals q[WIDTH-1]; combinational from q.
- so_dn  out  1  equals q[0]; combinational from q.
- cnt  out  CNT_W  number of shifts since the last load, clear or frame wrap.
- done  out  1  one-cycle pulse after the WIDTH-th shift.

Behaviour:
- Reset (clr=1, asynchronous): q=0, cnt=0, done=0.
  - Takes effect immediately and overrides all other inputs, including mid-frame.
  - First active edge after clr deasserts follows the normal rules below.
- en=0: q and cnt hold; done is 0 on the next edge.
- When en=1, each rising edge acts by mode:
  - Hold (00): q and cnt unchanged; done<=0.
  - Shift up (01): q[0]<=ser_a&ser_b; q[i]<=q[i-1] for i≥1.
  - Shift down (10): q[WIDTH-1]<=ser_dn; q[i]<=q[i+1] for i≤WIDTH-2.
  - Load (11): q<=d; cnt<=0; done<=0.
- Counter, on either shift mode:
  - If cnt==WIDTH-1: cnt<=0 and done<=1 (registered).
  - Otherwise: cnt<=cnt+1 and done<=0.
  - Shift up and shift down count identically.
  - Mixing directions within one frame is legal; every shift counts.
- done timing: high for exactly one cycle, the cycle after the edge that performs the WIDTH-th shift. Back-to-back frames give a pulse every WIDTH shifts.
- Latency: q, cnt and done are all registered, 1 cycle after the edge. so_up and so_dn follow q combinationally.
- Load on the same edge a frame would complete: the load wins, cnt=0 and done=0.
- Parallel load is synchronous; only clr is asynchronous.

Optional Feature:
- Macro UNIV_SHIFT_REG_PARITY_EN.
- Defined:
  - Adds output port par (1 bit), registered.
  - par is the XOR of the q value that results from the same edge, so par always matches q.
  - par resets to 0.
- Undefined: port par and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package uart_pkg holds:
  - the mode encodings as localparams MODE_HOLD, MODE_UP, MODE_DN, MODE_LOAD;
  - a 2-bit typedef shreg_mode_t.
- One natural sub-module, shreg_frame_cnt: the counter and the done pulse, parametrised by WIDTH. Its inputs are shift, load, en, clk and clr.
- The data path stays in the top module.

Test Plan:
1. clr=1 pulsed mid-frame (q=8'h5C, cnt=3), asynchronously between edges -> q=8'h00, cnt=0, done=0 before the next edge.
2. Shift-up bit sequence 1,0,0,0,1,1,0,1 (first to last), bits driven as the AND of ser_a and ser_b, starting from q=0 -> q=8'h8D after the 8th edge, done=1 for exactly one cycle, cnt=0.
3. Load d=8'hA5, then shift down 4× with ser_dn=0 -> q goes 52, 29, 14, 0A; so_dn before each shift is 1,0,1,0; cnt=4; done stays 0.
4. en=0 with mode=01 for 3 edges after a load of 8'h3C -> q=8'h3C, cnt=0, done=0 throughout.
5. 5 shifts, then load 8'hFF, then 8 shifts -> no done after the first 5; done fires only after the 8th post-load shift; cnt shows 0..7, then 0.
6. UNIV_SHIFT_REG_PARITY_EN defined, load 8'h07 -> par=1; one shift up with input 1 -> q=8'h0F, par=0.
